misrc_adc_packer: RTL and testbench
===================================

MISRC_ADC_PACKER -- requirements
Module: misrc_adc_packer

Interface
REQ-001 SHALL have parameter TEST_INIT, default 32'h00000000: first test-pattern word after arming.
REQ-002 SHALL have parameter DROP_W, default 16: width of drop_count.
REQ-003 adc_clk  in  1  sole clock; every register is updated on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 enable  in  1  capture enable; level-sensitive.
REQ-006 mode  in  2  packing mode; only sampled at arming.
REQ-007 clr_status  in  1  synchronous clear of overflow and drop_count.
REQ-008 adc0_data  in  12  ADC A sample.
REQ-009 adc1_data  in  12  ADC B sample.
REQ-010 gpio_data  in  8  auxiliary/GPIO bits.
REQ-011 fifo_full  in  1  full flag of the downstream async FIFO write side.
REQ-012 fifo_wdata  out  32  word to the FIFO.
REQ-013 fifo_winc  out  1  FIFO write strobe; one word per high cycle.
REQ-014 overflow  out  1  sticky: at least one word dropped.
REQ-015 drop_count  out  DROP_W  count of dropped words; saturates.
REQ-016 active  out  1  high while the block is armed (not IDLE).

Function
REQ-017 SHALL register all data inputs once per cycle (stage S1); the word is formed in the output register (stage S2); pin-to-fifo_winc latency SHALL be 2 cycles.
REQ-018 SHALL implement states IDLE, LO, HI.
REQ-019 IDLE: fifo_winc=0; on enable=1 it latches mode into mode_q, loads the test counter with TEST_INIT and goes to LO; the first sample is captured at the following edge.
REQ-020 mode_q=0 (dual): each captured sample set yields word {adc1,gpio[7:0],adc0} (adc0 in bits 11:0); the FSM stays in LO; one word per cycle.
REQ-021 mode_q=1 (A only): half-word h = {gpio[3:0],adc0}. The LO sample goes to bits 15:0, the HI sample to bits 31:16. The word is emitted after the HI sample. The FSM alternates LO->HI->LO.
REQ-022 mode_q=2 (B only): same as mode 1, using h = {gpio[7:4],adc1}.
REQ-023 mode_q=3 (test): ADC/GPIO inputs are ignored. Word = test counter. One word per cycle. The counter increments by 1 after every attempted word, written or dropped, and wraps from 32'hFFFFFFFF to 0.
REQ-024 A word whose output-register edge sees fifo_full=1 SHALL NOT be written (fifo_winc=0). It counts as dropped: overflow<=1 and drop_count<=drop_count+1, saturating at all-ones.
REQ-025 A dropped word in modes 1/2 SHALL NOT desynchronise pairing; the next LO sample starts a new word.
REQ-026 enable=0 in LO or HI: return to IDLE at that edge. A partial half-word in HI is discarded, not written and not counted. A word already in S2 SHALL still be presented.
REQ-027 mode changes while armed SHALL be ignored until re-arming through IDLE.
REQ-028 clr_status=1 clears overflow and drop_count. If a drop occurs in the same cycle, the clear wins and the drop is lost.
REQ-029 fifo_wdata SHALL hold its last value when fifo_winc=0.

Reset
REQ-030 With rst=1, at the next edge:
- state=IDLE, mode_q=0, test counter=TEST_INIT;
- S1/S2 cleared; fifo_winc=0, fifo_wdata=0;
- overflow=0, drop_count=0, active=0.
REQ-031 rst SHALL override enable and clr_status. Reset mid-pair discards the partial word; the output word in S2 is discarded too.

Verification
REQ-032 mode 0, adc0=12'h123, adc1=12'hABC, gpio=8'h5A, fifo_full=0 -> fifo_wdata=32'hABC5A123 with fifo_winc=1, 2 cycles after the sample, then every cycle.
REQ-033 mode 1, adc0 sequence 12'h001, 12'h002, gpio=8'hF0 -> single word 32'h00020001, winc high 1 of 2 cycles; mode 2, adc1 12'h111, 12'h222, gpio=8'hF0 -> 32'hF222F111.
REQ-034 mode 3, TEST_INIT=32'hFFFFFFFE, fifo_full=0 -> words FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-035 mode 3, fifo_full=1 for 3 word slots -> 3 counter values absent from output, drop_count=3, overflow=1; clr_status pulse -> both 0; DROP_W=2 with 5 drops -> drop_count=3.
REQ-036 mode 1, enable deasserted in HI -> no write of the partial word; re-arm with mode=0 -> dual words resume, mode_q=0.
REQ-037 rst pulse in HI with a word in S2 -> no fifo_winc after reset, all outputs 0, active=0.

Source files
------------

// File: rtl/misrc_adc_packer.sv
// misrc_adc_packer: packs dual 12-bit ADC samples plus GPIO bits into 32-bit
// words for a downstream async FIFO. It also provides a free-running test-pattern mode.
//
// Ports
//   adc_clk      sole clock, rising edge
//   rst          synchronous active-high reset
//   enable       capture enable (level)
//   mode         packing mode, latched only when arming from IDLE
//                0 dual, 1 ADC A only, 2 ADC B only, 3 test counter
//   clr_status   synchronous clear of overflow / drop_count
//   adc0_data    ADC A sample (12b)
//   adc1_data    ADC B sample (12b)
//   gpio_data    auxiliary bits (8b)
//   fifo_full    FIFO write-side full flag
//   fifo_wdata   word to FIFO, holds while fifo_winc=0
//   fifo_winc    FIFO write strobe
//   overflow     sticky: a word was dropped
//   drop_count   saturating count of dropped words
//   active       armed (state != IDLE)
module misrc_adc_packer #(
  parameter logic [31:0] TEST_INIT = 32'h0000_0000,
  parameter int unsigned DROP_W    = 16
) (
  input  logic              adc_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              clr_status,
  input  logic [11:0]       adc0_data,
  input  logic [11:0]       adc1_data,
  input  logic [7:0]        gpio_data,
  input  logic              fifo_full,
  output logic [31:0]       fifo_wdata,
  output logic              fifo_winc,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              active
);

  localparam int unsigned ADC_W  = 12;
  localparam int unsigned GPIO_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [WORD_W-1:0]   test_cnt;

  // Stage S1: raw input capture plus the tags that say how S2 should use it.
  logic [ADC_W-1:0]    s1_adc0;
  logic [ADC_W-1:0]    s1_adc1;
  logic [GPIO_W-1:0]   s1_gpio;
  logic                s1_vld;
  logic                s1_hi;
  logic [1:0]          s1_mode;

  logic [HALF_W-1:0]   lo_half;

  logic [HALF_W-1:0]   half_c;
  logic [WORD_W-1:0]   word_c;
  logic                emit_c;
  logic                single_c;

  // Word formation for stage S2 from the S1 contents.
  always_comb begin
    half_c   = '0;
    word_c   = '0;
    emit_c   = 1'b0;
    single_c = (s1_mode == 2'd1) || (s1_mode == 2'd2);
    if (s1_mode == 2'd1) begin
      half_c = {s1_gpio[3:0], s1_adc0};
    end else begin
      half_c = {s1_gpio[7:4], s1_adc1};
    end
    case (s1_mode)
      2'd0: begin
        word_c = {s1_adc1, s1_gpio, s1_adc0};
        emit_c = s1_vld;
      end
      2'd3: begin
        word_c = test_cnt;
        emit_c = s1_vld;
      end
      default: begin
        word_c = {half_c, lo_half};
        emit_c = s1_vld && s1_hi;
      end
    endcase
  end

  // FSM, S1 capture, S2 output register and status counters.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 2'd0;
      test_cnt   <= TEST_INIT;
      s1_adc0    <= '0;
      s1_adc1    <= '0;
      s1_gpio    <= '0;
      s1_vld     <= 1'b0;
      s1_hi      <= 1'b0;
      s1_mode    <= 2'd0;
      lo_half    <= '0;
      fifo_wdata <= '0;
      fifo_winc  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      active     <= 1'b0;
    end else begin
      s1_adc0   <= adc0_data;
      s1_adc1   <= adc1_data;
      s1_gpio   <= gpio_data;
      s1_vld    <= 1'b0;
      s1_hi     <= 1'b0;
      fifo_winc <= 1'b0;

      // S2: every attempted test word advances the counter, written or not.
      if (s1_vld && (s1_mode == 2'd3)) begin
        test_cnt <= test_cnt + WORD_W'(1);
      end
      if (s1_vld && single_c && !s1_hi) begin
        lo_half <= half_c;
      end
      if (emit_c) begin
        if (!fifo_full) begin
          fifo_winc  <= 1'b1;
          fifo_wdata <= word_c;
        end else begin
          overflow <= 1'b1;
          if (drop_count != {DROP_W{1'b1}}) begin
            drop_count <= drop_count + DROP_W'(1);
          end
        end
      end
      // Clear takes priority over a same-cycle drop.
      if (clr_status) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end

      // The arming load of test_cnt sits after the S2 increment so it wins.
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= LO;
            mode_q   <= mode;
            test_cnt <= TEST_INIT;
            active   <= 1'b1;
          end
        end
        LO, HI: begin
          if (!enable) begin
            // A pending low half is simply abandoned; next arm restarts at LO.
            state  <= IDLE;
            active <= 1'b0;
          end else begin
            s1_vld  <= 1'b1;
            s1_hi   <= (state == HI);
            s1_mode <= mode_q;
            if ((mode_q == 2'd1) || (mode_q == 2'd2)) begin
              state <= (state == LO) ? HI : LO;
            end else begin
              state <= LO;
            end
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_misrc_adc_packer.sv
// Directed self-checking bench for misrc_adc_packer. A second instance with
// DROP_W=2 shares all inputs and is used for drop-count saturation.
module tb_misrc_adc_packer;

  logic        adc_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        clr_status = 1'b0;
  logic [11:0] adc0_data = '0;
  logic [11:0] adc1_data = '0;
  logic [7:0]  gpio_data = '0;
  logic        fifo_full = 1'b0;

  logic [31:0] fifo_wdata, fifo_wdata2;
  logic        fifo_winc, fifo_winc2;
  logic        overflow, overflow2;
  logic [15:0] drop_count;
  logic [1:0]  drop_count2;
  logic        active, active2;

  int errors = 0;
  int checks = 0;

  always #5 adc_clk = ~adc_clk;

  misrc_adc_packer #(.TEST_INIT(32'hFFFF_FFFE), .DROP_W(16)) dut (
    .adc_clk(adc_clk), .rst(rst), .enable(enable), .mode(mode),
    .clr_status(clr_status), .adc0_data(adc0_data), .adc1_data(adc1_data),
    .gpio_data(gpio_data), .fifo_full(fifo_full), .fifo_wdata(fifo_wdata),
    .fifo_winc(fifo_winc), .overflow(overflow), .drop_count(drop_count),
    .active(active)
  );

  misrc_adc_packer #(.TEST_INIT(32'h0000_0000), .DROP_W(2)) dut2 (
    .adc_clk(adc_clk), .rst(rst), .enable(enable), .mode(mode),
    .clr_status(clr_status), .adc0_data(adc0_data), .adc1_data(adc1_data),
    .gpio_data(gpio_data), .fifo_full(fifo_full), .fifo_wdata(fifo_wdata2),
    .fifo_winc(fifo_winc2), .overflow(overflow2), .drop_count(drop_count2),
    .active(active2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge adc_clk);
      #1;
    end
  endtask

  task automatic drain();
    enable = 1'b0;
    tick(3);
  endtask

  initial begin
    // Reset
    tick(2);
    check("rst_winc", 32'(fifo_winc), 32'd0);
    check("rst_wdata", fifo_wdata, 32'h0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;
    tick(2);
    check("idle_winc", 32'(fifo_winc), 32'd0);

    // Mode 0: dual packing
    mode = 2'd0; adc0_data = 12'h123; adc1_data = 12'hABC; gpio_data = 8'h5A;
    enable = 1'b1;
    tick();                                        // arm
    check("m0_active", 32'(active), 32'd1);
    tick();                                        // S1 capture
    check("m0_lat1_winc", 32'(fifo_winc), 32'd0);
    tick();                                        // S2
    check("m0_winc", 32'(fifo_winc), 32'd1);
    check("m0_word", fifo_wdata, 32'hABC5_A123);
    adc0_data = 12'h456; adc1_data = 12'h789; gpio_data = 8'h00;
    tick();
    check("m0_winc2", 32'(fifo_winc), 32'd1);
    check("m0_word2", fifo_wdata, 32'hABC5_A123);
    tick();
    check("m0_word3", fifo_wdata, 32'h7890_0456);
    drain();
    check("m0_idle_active", 32'(active), 32'd0);
    check("m0_idle_winc", 32'(fifo_winc), 32'd0);
    check("m0_hold", fifo_wdata, 32'h7890_0456);

    // Mode 1: ADC A half-words
    mode = 2'd1; gpio_data = 8'hF0; adc0_data = 12'h001; enable = 1'b1;
    tick();                                        // arm
    tick();                                        // capture LO
    adc0_data = 12'h002;
    tick();                                        // capture HI, S2 holds low half
    check("m1_lo_winc", 32'(fifo_winc), 32'd0);
    mode = 2'd0;                                   // ignored while armed
    adc0_data = 12'h003;
    tick();
    check("m1_winc", 32'(fifo_winc), 32'd1);
    check("m1_word", fifo_wdata, 32'h0002_0001);
    adc0_data = 12'h004;
    tick();
    check("m1_gap_winc", 32'(fifo_winc), 32'd0);
    tick();
    check("m1_word2", fifo_wdata, 32'h0004_0003);
    check("m1_winc2", 32'(fifo_winc), 32'd1);
    drain();

    // Mode 2: ADC B half-words
    mode = 2'd2; gpio_data = 8'hF0; adc1_data = 12'h111; enable = 1'b1;
    tick();
    tick();
    adc1_data = 12'h222;
    tick();
    check("m2_lo_winc", 32'(fifo_winc), 32'd0);
    tick();
    check("m2_winc", 32'(fifo_winc), 32'd1);
    check("m2_word", fifo_wdata, 32'hF222_F111);
    drain();

    // Mode 1 aborted in HI, then re-arm in mode 0
    mode = 2'd1; adc0_data = 12'h0AA; gpio_data = 8'h00; enable = 1'b1;
    tick();                                        // arm
    tick();                                        // capture LO -> HI
    enable = 1'b0;
    tick();                                        // HI, disabled -> IDLE
    check("abort_active", 32'(active), 32'd0);
    check("abort_winc", 32'(fifo_winc), 32'd0);
    tick();
    check("abort_winc2", 32'(fifo_winc), 32'd0);
    tick();
    check("abort_winc3", 32'(fifo_winc), 32'd0);
    mode = 2'd0; adc0_data = 12'h321; adc1_data = 12'h654; gpio_data = 8'h87;
    enable = 1'b1;
    tick(3);
    check("rearm_winc", 32'(fifo_winc), 32'd1);
    check("rearm_word", fifo_wdata, 32'h6548_7321);
    tick();
    check("rearm_winc2", 32'(fifo_winc), 32'd1);
    drain();

    // Mode 3: test counter wraps
    mode = 2'd3; adc0_data = 12'hFFF; enable = 1'b1;
    tick(3);
    check("m3_w0", fifo_wdata, 32'hFFFF_FFFE);
    check("m3_winc", 32'(fifo_winc), 32'd1);
    tick();
    check("m3_w1", fifo_wdata, 32'hFFFF_FFFF);
    tick();
    check("m3_w2", fifo_wdata, 32'h0000_0000);
    tick();
    check("m3_w3", fifo_wdata, 32'h0000_0001);
    drain();

    // Mode 3 with drops
    enable = 1'b1;
    tick(2);                                       // arm, capture
    fifo_full = 1'b1;
    tick();
    check("drop_winc0", 32'(fifo_winc), 32'd0);
    tick();
    check("drop_winc1", 32'(fifo_winc), 32'd0);
    tick();
    check("drop_winc2", 32'(fifo_winc), 32'd0);
    fifo_full = 1'b0;
    tick();
    check("drop_resume_winc", 32'(fifo_winc), 32'd1);
    check("drop_resume_word", fifo_wdata, 32'h0000_0001);
    check("drop_cnt3", 32'(drop_count), 32'd3);
    check("drop_ovf", 32'(overflow), 32'd1);
    fifo_full = 1'b1;
    tick(2);
    fifo_full = 1'b0;
    check("drop_cnt5", 32'(drop_count), 32'd5);
    check("drop_sat2", 32'(drop_count2), 32'd3);
    check("drop_ovf2", 32'(overflow2), 32'd1);
    tick();
    check("drop_after_word", fifo_wdata, 32'h0000_0004);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_cnt", 32'(drop_count), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_cnt2", 32'(drop_count2), 32'd0);
    // Clear and drop in the same cycle: clear wins
    fifo_full = 1'b1; clr_status = 1'b1;
    tick();
    fifo_full = 1'b0; clr_status = 1'b0;
    check("clrwin_cnt", 32'(drop_count), 32'd0);
    check("clrwin_ovf", 32'(overflow), 32'd0);
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    check("drop_after_clr", 32'(drop_count), 32'd1);
    drain();

    // Reset in HI with a word in S2
    mode = 2'd1; adc0_data = 12'h0BB; gpio_data = 8'h0C; enable = 1'b1;
    tick(4);                                       // arm, LO, HI, LO -> now HI
    check("prerst_winc", 32'(fifo_winc), 32'd1);
    check("prerst_word", fifo_wdata, 32'hC0BB_C0BB);
    rst = 1'b1;
    tick();
    check("rst2_winc", 32'(fifo_winc), 32'd0);
    check("rst2_wdata", fifo_wdata, 32'h0);
    check("rst2_active", 32'(active), 32'd0);
    check("rst2_ovf", 32'(overflow), 32'd0);
    check("rst2_drop", 32'(drop_count), 32'd0);
    rst = 1'b0; enable = 1'b0;
    tick();
    check("postrst_winc", 32'(fifo_winc), 32'd0);
    tick();
    check("postrst_winc2", 32'(fifo_winc), 32'd0);
    check("postrst_active", 32'(active), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
